// File: rtl/alu_result_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage_if
// Description : Upstream and downstream handshake bundle for alu_result_stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_stage_if #(
    parameter int WIDTH = 128
);
    logic             inValid;
    logic             inReady;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] result;
    logic             carryFlag;
    logic             zeroFlag;
    logic             overFlowFlag;
    logic             signFlag;

    logic             outValid;
    logic             outReady;
    logic [3:0]       outOpcode;
    logic [WIDTH-1:0] outResult;
    logic [3:0]       outFlags;

    modport master (
        output inValid, opcode, result, carryFlag, zeroFlag, overFlowFlag, signFlag,
        output outReady,
        input  inReady, outValid, outOpcode, outResult, outFlags
    );

    modport slave (
        input  inValid, opcode, result, carryFlag, zeroFlag, overFlowFlag, signFlag,
        input  outReady,
        output inReady, outValid, outOpcode, outResult, outFlags
    );
endinterface
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_stage
// Description : 2-entry result/flag FIFO with sticky status and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int WIDTH = 128,
    parameter int CNTW  = 16
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    alu_result_stage_if.slave    bus,
    input  wire logic            clearSticky,
    output logic [3:0]           stickyFlags,
    output logic                 illegalOp,
    output logic [7:0]           overflowCount,
    output logic [CNTW-1:0]      opCount
);
    localparam logic [3:0] C_MAX_LEGAL_OP = 4'd8;
    localparam logic [7:0] C_OVF_MAX      = 8'hFF;
    localparam logic [1:0] C_DEPTH        = 2'd2;

    logic [3:0]       r_opcode [2];
    logic [WIDTH-1:0] r_result [2];
    logic [3:0]       r_flags  [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic [3:0]       r_sticky;
    logic             r_illegal;
    logic [7:0]       r_ovf_count;
    logic [CNTW-1:0]  r_op_count;

    logic             w_ready;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic [3:0]       w_in_flags;
    logic             w_in_illegal;
    logic             w_in_ovf;

    // Ready depends only on registered occupancy, so outReady never reaches inReady.
    assign w_ready      = (r_count < C_DEPTH);
    assign w_valid      = (r_count != 2'd0);
    assign w_push       = bus.inValid && w_ready;
    assign w_pop        = w_valid && bus.outReady;
    assign w_in_flags   = {bus.carryFlag, bus.zeroFlag, bus.overFlowFlag, bus.signFlag};
    assign w_in_illegal = (bus.opcode > C_MAX_LEGAL_OP);
    assign w_in_ovf     = bus.overFlowFlag;

    assign bus.inReady   = w_ready;
    assign bus.outValid  = w_valid;
    assign bus.outOpcode = w_valid ? r_opcode[r_rd_ptr] : 4'd0;
    assign bus.outResult = w_valid ? r_result[r_rd_ptr] : '0;
    assign bus.outFlags  = w_valid ? r_flags[r_rd_ptr]  : 4'd0;

    assign stickyFlags   = r_sticky;
    assign illegalOp     = r_illegal;
    assign overflowCount = r_ovf_count;
    assign opCount       = r_op_count;

    // Storage payload is not reset; head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_opcode[r_wr_ptr] <= bus.opcode;
            r_result[r_wr_ptr] <= bus.result;
            r_flags[r_wr_ptr]  <= w_in_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A clear in the same cycle as a push keeps only the pushed entry's contribution.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky    <= 4'd0;
            r_illegal   <= 1'b0;
            r_ovf_count <= 8'd0;
        end else if (clearSticky) begin
            r_sticky    <= w_push ? w_in_flags : 4'd0;
            r_illegal   <= w_push && w_in_illegal;
            r_ovf_count <= (w_push && w_in_ovf) ? 8'd1 : 8'd0;
        end else if (w_push) begin
            r_sticky  <= r_sticky | w_in_flags;
            r_illegal <= r_illegal | w_in_illegal;
            if (w_in_ovf && (r_ovf_count != C_OVF_MAX)) begin
                r_ovf_count <= r_ovf_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_pop) begin
            r_op_count <= r_op_count + CNTW'(1);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Randomized and directed bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;
    localparam int WIDTH = 128;
    localparam int CNTW  = 16;

    typedef struct {
        logic [3:0]       op;
        logic [WIDTH-1:0] res;
        logic [3:0]       fl;
    } entry_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            clearSticky;
    logic [3:0]      stickyFlags;
    logic            illegalOp;
    logic [7:0]      overflowCount;
    logic [CNTW-1:0] opCount;

    alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

    alu_result_stage #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clearSticky  (clearSticky),
        .stickyFlags  (stickyFlags),
        .illegalOp    (illegalOp),
        .overflowCount(overflowCount),
        .opCount      (opCount)
    );

    always #5 clk = ~clk;

    entry_t          mq[$];
    logic [3:0]      m_sticky;
    logic            m_illegal;
    int              m_ovf;
    logic [CNTW-1:0] m_opcnt;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_res();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_sticky  = 4'd0;
        m_illegal = 1'b0;
        m_ovf     = 0;
        m_opcnt   = '0;
    endtask

    task automatic compare_all();
        entry_t h;
        h.op  = 4'd0;
        h.res = '0;
        h.fl  = 4'd0;
        if (mq.size() > 0) h = mq[0];
        check("inReady",   bus.inReady,  mq.size() < 2);
        check("outValid",  bus.outValid, mq.size() > 0);
        check("outOpcode", bus.outOpcode, h.op);
        check("outResult", bus.outResult, h.res);
        check("outFlags",  bus.outFlags,  h.fl);
        check("sticky",    stickyFlags,   m_sticky);
        check("illegal",   illegalOp,     m_illegal);
        check("ovfCount",  overflowCount, m_ovf[7:0]);
        check("opCount",   opCount,       m_opcnt);
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance the model.
    task automatic cycle(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] res,
                         input logic [3:0] fl, input logic ordy, input logic clr);
        logic   push;
        logic   pop;
        entry_t e;
        bus.inValid  = v;
        bus.opcode   = op;
        bus.result   = res;
        {bus.carryFlag, bus.zeroFlag, bus.overFlowFlag, bus.signFlag} = fl;
        bus.outReady = ordy;
        clearSticky  = clr;
        @(negedge clk);
        compare_all();
        push = v && (mq.size() < 2);
        pop  = ordy && (mq.size() > 0);
        if (clr) begin
            m_sticky  = push ? fl : 4'd0;
            m_illegal = push && (op > 4'd8);
            m_ovf     = (push && fl[1]) ? 1 : 0;
        end else if (push) begin
            m_sticky = m_sticky | fl;
            if (op > 4'd8) m_illegal = 1'b1;
            if (fl[1] && m_ovf < 255) m_ovf = m_ovf + 1;
        end
        if (pop) begin
            void'(mq.pop_front());
            m_opcnt = m_opcnt + 1'b1;
        end
        if (push) begin
            e.op  = op;
            e.res = res;
            e.fl  = fl;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.inValid  = 1'($urandom);
        bus.opcode   = 4'($urandom);
        bus.result   = rand_res();
        {bus.carryFlag, bus.zeroFlag, bus.overFlowFlag, bus.signFlag} = 4'($urandom);
        bus.outReady = 1'($urandom);
        clearSticky  = 1'($urandom);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        model_clear();
        do_reset();
        check("rst_outValid", bus.outValid, 1'b0);
        check("rst_inReady",  bus.inReady,  1'b1);
        check("rst_outResult", bus.outResult, '0);

        // Single entry, one-cycle latency, popped next cycle.
        cycle(1'b1, 4'd0, 128'h5, 4'b0100, 1'b1, 1'b0);
        check("lat_outValid", bus.outValid, 1'b1);
        check("lat_outResult", bus.outResult, 128'h5);
        check("lat_outFlags", bus.outFlags, 4'b0100);
        cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b0);
        check("lat_opCount", opCount, 16'd1);

        // Backpressure: fill, ignore third, drain in order.
        do_reset();
        cycle(1'b1, 4'd1, 128'hA, 4'b0001, 1'b0, 1'b0);
        cycle(1'b1, 4'd2, 128'hB, 4'b0010, 1'b0, 1'b0);
        check("full_inReady", bus.inReady, 1'b0);
        cycle(1'b1, 4'd3, 128'hC, 4'b1111, 1'b0, 1'b0);
        check("full_head", bus.outResult, 128'hA);
        cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b0);
        check("drain_second", bus.outResult, 128'hB);
        cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b0);
        check("drain_opCount", opCount, 16'd2);
        check("drain_sticky", stickyFlags, 4'b0011);

        // Streaming throughput.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 4'($urandom_range(0, 8)), rand_res(), 4'($urandom), 1'b1, 1'b0);
        check("stream_opCount", opCount, 16'd9);

        // Overflow saturation then clear with concurrent push.
        do_reset();
        for (int i = 0; i < 300; i++) cycle(1'b1, 4'd0, rand_res(), 4'($urandom) | 4'b0010, 1'b1, 1'b0);
        check("sat_ovf", overflowCount, 8'd255);
        cycle(1'b1, 4'd0, rand_res(), 4'b1000, 1'b1, 1'b1);
        check("clr_sticky", stickyFlags, 4'b1000);
        check("clr_ovf", overflowCount, 8'd0);

        // Illegal opcode is flagged yet forwarded.
        do_reset();
        cycle(1'b1, 4'd12, 128'h77, 4'd0, 1'b0, 1'b0);
        check("ill_flag", illegalOp, 1'b1);
        check("ill_opcode", bus.outOpcode, 4'd12);
        cycle(1'b1, 4'd3, 128'h78, 4'd0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b0);
        check("ill_hold", illegalOp, 1'b1);
        cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b1);
        check("ill_clear", illegalOp, 1'b0);

        // Reset with two entries stored.
        do_reset();
        cycle(1'b1, 4'd9, rand_res(), 4'b1111, 1'b0, 1'b0);
        cycle(1'b1, 4'd1, rand_res(), 4'b0010, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, '0, 4'd0, 1'b1, 1'b0);
        do_reset();
        check("mrst_outValid", bus.outValid, 1'b0);
        check("mrst_inReady", bus.inReady, 1'b1);
        check("mrst_opCount", opCount, 16'd0);
        check("mrst_sticky", stickyFlags, 4'd0);
        check("mrst_illegal", illegalOp, 1'b0);
        check("mrst_ovf", overflowCount, 8'd0);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 99) < 65), 4'($urandom), rand_res(), 4'($urandom),
                      1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 5));
            end
        end
        @(negedge clk);
        compare_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
